sum4_scheduler: RTL and testbench
=================================

# sum4_scheduler

Round-robin scheduler and sequencer that shares one four-operand summing datapath (operand registers A–D, a single two-input adder and an accumulator) between two requesters. It arbitrates, captures the winner's four operands, steps the adder through three accumulate cycles, then returns the sum with a per-client completion pulse. It sits between two client blocks and the shared adder resource, replacing ad-hoc go/output_enable sequencing.

## Interface
- W, 8, width of each operand
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- req0  input  1  client 0 request; held high with stable ops0 until gnt0 seen
- ops0  input  4*W  client 0 operands {D,C,B,A}, A in bits [W-1:0]
- req1  input  1  client 1 request; same rules as req0
- ops1  input  4*W  client 1 operands {D,C,B,A}
- gnt0  output  1  one-cycle grant to client 0; ops0 captured this cycle
- gnt1  output  1  one-cycle grant to client 1
- busy  output  1  high in every state except IDLE
- done0  output  1  one-cycle pulse, client 0 result valid on sum
- done1  output  1  one-cycle pulse, client 1 result valid on sum
- sum  output  W+2  registered result A+B+C+D; held until next completion

## Operation
- States: IDLE, LOAD, ADD1, ADD2, ADD3, DONE; one cycle each except IDLE.
- IDLE: arbitration evaluated only here. No req -> stay. Any req -> LOAD, winner latched in `owner`.
- Arbitration: single req wins. Both req -> winner is client not equal to `last`. `last` updates to winner on IDLE->LOAD. Reset value of `last` = 1, so client 0 wins first tie.
- LOAD: gnt_owner = 1; owner's ops registered into A,B,C,D at end of cycle. -> ADD1.
- ADD1: acc <= A+B. ADD2: acc <= acc+C. ADD3: sum <= acc+D. Each -> next state.
- DONE: done_owner = 1; -> IDLE.
- Width: acc and sum are W+2 bits, zero-extended operands; no overflow possible (max 4*(2^W-1)).
- Requests while busy: ignored, not queued; client keeps req high and is arbitrated at next IDLE.
- Served client must drop req by DONE; req still high in IDLE is a new request.
- Exactly one of gnt0/gnt1 ever high; never both done0/done1 high; gnt and done never high outside LOAD/DONE.

## Timing
- Reset (rst high at an edge): state=IDLE, gnt0=gnt1=0, done0=done1=0, busy=0, sum=0, acc=0, A–D=0, last=1, owner=0.
- Reset mid-operation: transaction aborted, no done pulse, sum forced to 0; client must re-request. rst overrides all other inputs.
- Latency: req high in IDLE at cycle 0 -> gnt at cycle 1 -> done and valid sum at cycle 5. busy high cycles 1–5.
- Back-to-back: DONE at cycle 5 -> IDLE cycle 6 -> next grant cycle 7; throughput one result per 6 cycles.
- sum changes only at ADD3->DONE edge (and reset); stable in DONE and all following IDLE cycles.
- Ops change after gnt cycle do not affect the running sum.

## Test plan
- Reset: assert rst 2 cycles -> all outputs 0, busy 0; first tie later goes to client 0.
- Single request: req0, ops0={4,3,2,1} at cycle 0 -> gnt0 cycle 1, done0 cycle 5, sum=10, busy cycles 1–5, sum still 10 at cycle 8.
- Max values: req1, ops1={255,255,255,255} -> done1 at +5, sum=1020, no truncation.
- Contention/round-robin: req0 and req1 held together, ops0 sum 10, ops1={40,30,20,10} -> gnt0 c1, done0 c5 sum=10; gnt1 c7, done1 c11 sum=100; client 0 re-requesting then wins c13.
- Late request while busy: req1 rises cycle 3 during client 0 job -> no gnt1 before cycle 7; ops1 change after gnt1 has no effect on sum.
- Reset mid-operation: rst at cycle 3 of a job -> no done pulse, sum=0, IDLE; re-request completes normally with correct sum.

Source files
------------

// File: rtl/sum4_scheduler.sv
// sum4_scheduler: round-robin sequencer sharing one adder/accumulator between two four-operand sum requesters
module sum4_scheduler #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic [4*W-1:0] ops0,
    input  logic           req1,
    input  logic [4*W-1:0] ops1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           busy,
    output logic           done0,
    output logic           done1,
    output logic [W+1:0]   sum
);
    typedef enum logic [2:0] {IDLE, LOAD, ADD1, ADD2, ADD3, DONE} state_t;
    state_t state, state_nx;
    logic owner, last, win;
    logic [W-1:0] a, b, c, d;
    logic [W+1:0] acc;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            if (state == IDLE && (req0 || req1)) begin
                owner <= win;
                last  <= win;
            end
        end
    end
    always_comb begin
        win      = (req0 && req1) ? ~last : req1;
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = (req0 || req1) ? LOAD : IDLE;
            LOAD:    state_nx = ADD1;
            ADD1:    state_nx = ADD2;
            ADD2:    state_nx = ADD3;
            ADD3:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        gnt0  = state == LOAD && !owner;
        gnt1  = state == LOAD && owner;
        done0 = state == DONE && !owner;
        done1 = state == DONE && owner;
        busy  = state != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            {d, c, b, a} <= '0;
            acc          <= '0;
            sum          <= '0;
        end else begin
            unique case (state)
                LOAD:    {d, c, b, a} <= owner ? ops1 : ops0;
                ADD1:    acc <= {2'b00, a} + {2'b00, b};
                ADD2:    acc <= acc + {2'b00, c};
                ADD3:    sum <= acc + {2'b00, d};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sum4_scheduler.sv
// tb_sum4_scheduler: scenario tasks with a scoreboard of expected (client, sum) results
module tb_sum4_scheduler;
    localparam int W = 8;
    typedef struct packed {
        logic         client;
        logic [W+1:0] sum;
    } exp_t;
    logic clk = 1'b0;
    logic rst, req0, req1, gnt0, gnt1, busy, done0, done1;
    logic [4*W-1:0] ops0, ops1;
    logic [W+1:0] sum;
    exp_t sb[$];
    exp_t e;
    logic [4:0] ev;
    int total = 0;
    int bad = 0;
    sum4_scheduler #(.W(W)) dut (
        .clk(clk), .rst(rst), .req0(req0), .ops0(ops0), .req1(req1), .ops1(ops1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done0(done0), .done1(done1), .sum(sum)
    );
    always #5 clk = ~clk;
    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        ops0 = 32'hffff_ffff; ops1 = 32'hffff_ffff;
        repeat (2) @(negedge clk);
        total++;
        if ({gnt0, gnt1, done0, done1, busy} !== 5'b0) begin
            bad++; $display("FAIL reset_ctl: got %b want 00000", {gnt0, gnt1, done0, done1, busy});
        end
        total++;
        if (sum !== '0) begin
            bad++; $display("FAIL reset_sum: got %0d want 0", sum);
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    endtask
    task automatic test_single();
        req0 = 1'b1; ops0 = {8'd4, 8'd3, 8'd2, 8'd1};
        sb.push_back('{1'b0, 10'd10});
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            ev = {c == 1, 1'b0, c == 5, 1'b0, c >= 1 && c <= 5};
            total++;
            if ({gnt0, gnt1, done0, done1, busy} !== ev) begin
                bad++; $display("FAIL single_ctl c%0d: got %b want %b", c, {gnt0, gnt1, done0, done1, busy}, ev);
            end
            if (done0 || done1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL single_sb: done with nothing expected");
                end else begin
                    e = sb.pop_front();
                    if ({done1, sum} !== {e.client, e.sum}) begin
                        bad++; $display("FAIL single_result: got client=%0d sum=%0d want client=%0d sum=%0d", done1, sum, e.client, e.sum);
                    end
                end
            end
            if (c == 1) req0 = 1'b0;
        end
        total++;
        if (sum !== 10'd10) begin
            bad++; $display("FAIL single_hold: got %0d want 10", sum);
        end
    endtask
    task automatic test_max();
        req1 = 1'b1; ops1 = {4{8'd255}};
        sb.push_back('{1'b1, 10'd1020});
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            ev = {1'b0, c == 1, 1'b0, c == 5, c >= 1 && c <= 5};
            total++;
            if ({gnt0, gnt1, done0, done1, busy} !== ev) begin
                bad++; $display("FAIL max_ctl c%0d: got %b want %b", c, {gnt0, gnt1, done0, done1, busy}, ev);
            end
            if (done0 || done1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL max_sb: done with nothing expected");
                end else begin
                    e = sb.pop_front();
                    if ({done1, sum} !== {e.client, e.sum}) begin
                        bad++; $display("FAIL max_result: got client=%0d sum=%0d want client=%0d sum=%0d", done1, sum, e.client, e.sum);
                    end
                end
            end
            if (c == 1) req1 = 1'b0;
        end
    endtask
    task automatic test_contention();
        req0 = 1'b1; ops0 = {8'd4, 8'd3, 8'd2, 8'd1};
        req1 = 1'b1; ops1 = {8'd40, 8'd30, 8'd20, 8'd10};
        sb.push_back('{1'b0, 10'd10});
        sb.push_back('{1'b1, 10'd100});
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            ev = {c == 1 || c == 13, c == 7 || c == 19, c == 5 || c == 17, c == 11 || c == 23, c % 6 != 0};
            total++;
            if ({gnt0, gnt1, done0, done1, busy} !== ev) begin
                bad++; $display("FAIL rr_ctl c%0d: got %b want %b", c, {gnt0, gnt1, done0, done1, busy}, ev);
            end
            if (done0 || done1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL rr_sb: done with nothing expected");
                end else begin
                    e = sb.pop_front();
                    if ({done1, sum} !== {e.client, e.sum}) begin
                        bad++; $display("FAIL rr_result: got client=%0d sum=%0d want client=%0d sum=%0d", done1, sum, e.client, e.sum);
                    end
                end
            end
            if (c == 1 || c == 13) req0 = 1'b0;
            if (c == 7 || c == 19) req1 = 1'b0;
            if (c == 8) begin
                req0 = 1'b1; req1 = 1'b1;
                sb.push_back('{1'b0, 10'd10});
                sb.push_back('{1'b1, 10'd100});
            end
        end
    endtask
    task automatic test_late();
        req0 = 1'b1; ops0 = {8'd8, 8'd7, 8'd6, 8'd5};
        sb.push_back('{1'b0, 10'd26});
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            ev = {c == 1, c == 7, c == 5, c == 11, c % 6 != 0};
            total++;
            if ({gnt0, gnt1, done0, done1, busy} !== ev) begin
                bad++; $display("FAIL late_ctl c%0d: got %b want %b", c, {gnt0, gnt1, done0, done1, busy}, ev);
            end
            if (done0 || done1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL late_sb: done with nothing expected");
                end else begin
                    e = sb.pop_front();
                    if ({done1, sum} !== {e.client, e.sum}) begin
                        bad++; $display("FAIL late_result: got client=%0d sum=%0d want client=%0d sum=%0d", done1, sum, e.client, e.sum);
                    end
                end
            end
            if (c == 1) req0 = 1'b0;
            if (c == 3) begin
                req1 = 1'b1; ops1 = {8'd6, 8'd7, 8'd8, 8'd9};
                sb.push_back('{1'b1, 10'd30});
            end
            if (c == 7) req1 = 1'b0;
            if (c == 8) ops1 = {4{8'd200}};
        end
    endtask
    task automatic test_reset_mid();
        req0 = 1'b1; ops0 = {8'd40, 8'd30, 8'd20, 8'd10};
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            ev = {c == 1 || c == 9, 1'b0, c == 13, 1'b0, (c >= 1 && c <= 3) || (c >= 9 && c <= 13)};
            total++;
            if ({gnt0, gnt1, done0, done1, busy} !== ev) begin
                bad++; $display("FAIL rmid_ctl c%0d: got %b want %b", c, {gnt0, gnt1, done0, done1, busy}, ev);
            end
            if (done0 || done1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL rmid_sb: done with nothing expected");
                end else begin
                    e = sb.pop_front();
                    if ({done1, sum} !== {e.client, e.sum}) begin
                        bad++; $display("FAIL rmid_result: got client=%0d sum=%0d want client=%0d sum=%0d", done1, sum, e.client, e.sum);
                    end
                end
            end
            if (c == 4) begin
                total++;
                if (sum !== '0) begin
                    bad++; $display("FAIL rmid_sum_cleared: got %0d want 0", sum);
                end
                rst = 1'b0;
            end
            if (c == 1 || c == 9) req0 = 1'b0;
            if (c == 3) rst = 1'b1;
            if (c == 8) begin
                req0 = 1'b1;
                sb.push_back('{1'b0, 10'd100});
            end
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_max();
        test_contention();
        test_late();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
